dff_response_checker: RTL

Synthesizable response checker for the D flip-flop verification environment. It is the receiving end of the stimulus path: the bench drives `d` and the DUT's reset, and this block observes `d`, the DUT reset and `q`. It keeps a one-cycle reference model of the flip-flop and compares every DUT output against it. It reports check and error counts and captures the first failure for the bench to read at end of test.

---
 rtl/dff_response_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dff_response_checker.sv
// dff_response_checker
//   Response checker for a single D flip-flop under test. It keeps a one-cycle
//   reference model of the flop (exp), waits WARMUP edges after the DUT comes
//   out of reset with checking enabled, and then compares q against exp on
//   every enabled edge. It counts checks and mismatches and captures the first
//   failure.
//
//   Optional feature macro: DFF_CHK_HALT_ON_ERR_EN
//     defined   -> the first mismatch moves CHECK -> FAULT. FAULT holds until
//                  rst, and all counters stay frozen.
//     undefined -> FAULT is unreachable and checking continues after errors.
//
// Ports
//   clk            in   sampling clock (shared with the DUT), rising edge
//   rst            in   checker reset, asynchronous, active-low
//   en             in   checking enable
//   dut_rst        in   DUT reset level (active-high)
//   d              in   stimulus presented to the DUT
//   q              in   DUT output
//   state          out  0 IDLE, 1 WARMUP, 2 CHECK, 3 FAULT
//   check_cnt      out  comparisons performed (saturating)
//   err_cnt        out  mismatches found (saturating)
//   err            out  sticky error flag
//   first_err_cyc  out  cycle count at the first mismatch
//   first_err_exp  out  expected value at the first mismatch
//   first_err_obs  out  observed q at the first mismatch
module dff_response_checker #(
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 16,
    parameter int WARMUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dut_rst,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_err_cyc,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_obs
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_CHECK = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Sized to hold WARMUP itself: the count reaches WARMUP on the edge that
    // leaves WARMUP and is cleared one edge later.
    localparam int WC_W = $clog2(WARMUP + 1);

    state_t           cur;
    state_t           nxt;
    logic [WIDTH-1:0] exp;
    logic [CNT_W-1:0] cyc;
    logic [WC_W-1:0]  wcnt;

    logic qual;       // edge where the DUT is running and checking is enabled
    logic mismatch;
    logic last_warm;
    logic do_cmp;
    logic cmp_fail;

    assign qual      = en && !dut_rst;
    assign mismatch  = (q != exp);
    assign last_warm = (wcnt == WC_W'(WARMUP - 1));
    assign state     = cur;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_IDLE;
        else      cur <= nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE:  if (qual) nxt = S_WARM;
            S_WARM: begin
                if (!qual)         nxt = S_IDLE;
                else if (last_warm) nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!qual) nxt = S_IDLE;
`ifdef DFF_CHK_HALT_ON_ERR_EN
                else if (mismatch) nxt = S_FAULT;
`endif
            end
            // Only rst leaves FAULT; en and dut_rst are ignored here.
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // The edge that drops en or raises dut_rst leaves CHECK and performs no
    // compare, so a mismatch on that edge is never counted.
    always_comb begin
        do_cmp   = (cur == S_CHECK) && qual;
        cmp_fail = do_cmp && mismatch;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp           <= '0;
            cyc           <= '0;
            wcnt          <= '0;
            check_cnt     <= '0;
            err_cnt       <= '0;
            err           <= 1'b0;
            first_err_cyc <= '0;
            first_err_exp <= '0;
            first_err_obs <= '0;
        end else begin
            // One-cycle flop model: a synchronous reset wins over d.
            exp <= dut_rst ? '0 : d;

            if (cyc != '1) cyc <= cyc + CNT_W'(1);

            wcnt <= (cur == S_WARM && qual) ? wcnt + WC_W'(1) : '0;

            if (do_cmp && check_cnt != '1) check_cnt <= check_cnt + CNT_W'(1);

            if (cmp_fail) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                err <= 1'b1;
                // Capture only the first failure; later ones leave it alone.
                if (!err) begin
                    first_err_cyc <= cyc;
                    first_err_exp <= exp;
                    first_err_obs <= q;
                end
            end
        end
    end

endmodule
